// File: rtl/ext_pipe.sv
// Pipelined immediate extender with valid/ready handshakes on both sides.
// Optional EXT_SKID_EN adds a skid register so that InReady is registered.
module ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Flush,
  input  logic [IN_W-1:0]  DataIn,
  input  logic [1:0]       ExtOp,
  input  logic             InValid,
  output logic             InReady,
  output logic [OUT_W-1:0] ExtOut,
  output logic             OutValid,
  input  logic             OutReady
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] FULL1 = 2'd1;

  logic [1:0]       state;
  logic [OUT_W-1:0] sext, zext, extVal, outReg;
  logic             accept, xfer;

  always_comb begin
    sext = {{(OUT_W-IN_W){DataIn[IN_W-1]}}, DataIn};
    zext = {{(OUT_W-IN_W){1'b0}}, DataIn};
    case (ExtOp)
      2'd0:    extVal = sext;
      2'd1:    extVal = zext;
      2'd2:    extVal = zext << IN_W;
      default: extVal = sext << 2;
    endcase
  end

  assign OutValid = (state != EMPTY);
  assign ExtOut   = outReg;
  assign xfer     = OutValid && OutReady;
  // A flushed cycle never accepts, even when InReady is high.
  assign accept   = InValid && InReady && !Flush;

`ifdef EXT_SKID_EN
  localparam logic [1:0] FULL2 = 2'd2;

  logic [OUT_W-1:0] skidReg;
  logic             inReadyReg;
  logic [1:0]       stateNext;

  assign InReady = Reset && inReadyReg;

  always_comb begin
    stateNext = state;
    case (state)
      EMPTY:   if (accept) stateNext = FULL1;
      FULL1: begin
        if (accept && !xfer)      stateNext = FULL2;
        else if (!accept && xfer) stateNext = EMPTY;
      end
      FULL2:   if (xfer) stateNext = FULL1;
      default: stateNext = EMPTY;
    endcase
    if (Flush) stateNext = EMPTY;
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state      <= EMPTY;
      outReg     <= '0;
      skidReg    <= '0;
      inReadyReg <= 1'b1;
    end else begin
      state      <= stateNext;
      inReadyReg <= (stateNext != FULL2);
      if (!Flush) begin
        case (state)
          EMPTY: if (accept) outReg <= extVal;
          FULL1: begin
            if (accept && xfer) outReg  <= extVal;
            else if (accept)    skidReg <= extVal;
          end
          FULL2: if (xfer) outReg <= skidReg;
          default: ;
        endcase
      end
    end
  end
`else
  assign InReady = Reset && (!OutValid || OutReady);

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state  <= EMPTY;
      outReg <= '0;
    end else if (Flush) begin
      state <= EMPTY;
    end else if (accept) begin
      outReg <= extVal;
      state  <= FULL1;
    end else if (xfer) begin
      state <= EMPTY;
    end
  end
`endif

endmodule
